// File: rtl/tlp_win_trigger.sv
// TLP capture-window trigger.
// Watches a TLP stream and arms on a pulse. It starts forwarding beats into a
// capture window on the first SOP whose fmt/type byte matches the trigger.
// It stops after enough beats have been forwarded, or when the window is full.
module tlp_win_trigger #(
    parameter int MAX_BEATS = 4095
) (
    input  logic        trn_clk,
    input  logic        trn_rst,
    input  logic        st_valid0,
    input  logic        st_ready0,
    input  logic        st_sop0,
    input  logic        st_eop0,
    input  logic [7:0]  st_be0,
    input  logic [63:0] st_data0,
    input  logic        arm,
    input  logic        abort,
    input  logic [7:0]  trig_mask,
    input  logic [7:0]  trig_value,
    input  logic [11:0] beat_limit,
    output logic        cap_valid,
    output logic        cap_ready,
    output logic        cap_sop,
    output logic        cap_eop,
    output logic [7:0]  cap_be,
    output logic [63:0] cap_data,
    output logic        win_rst,
    output logic [1:0]  state,
    output logic        done,
    output logic [11:0] beat_cnt,
    output logic [15:0] tlp_cnt
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [12:0] MAX_CNT = 13'(MAX_BEATS);

    logic [1:0]  state_q,    state_d;
    logic [11:0] limit_q,    limit_d;
    logic [11:0] beatCnt_q,  beatCnt_d;
    logic [15:0] tlpCnt_q,   tlpCnt_d;
    logic        winRst_q,   winRst_d;
    logic        capValid_q, capValid_d;
    logic        capSop_q,   capSop_d;
    logic        capEop_q,   capEop_d;
    logic [7:0]  capBe_q,    capBe_d;
    logic [63:0] capData_q,  capData_d;

    logic        beat;
    logic        match;
    logic        fwd;
    logic [11:0] limEff;
    logic [11:0] limMin;
    logic [12:0] cntNext;

    // Next-state logic: abort beats arm, arm beats forwarding, and the
    // match beat itself may already complete the capture.
    always_comb begin
        beat       = st_valid0 && st_ready0;
        match      = beat && st_sop0 &&
                     ((st_data0[63:56] & trig_mask) == (trig_value & trig_mask));
        fwd        = 1'b0;
        state_d    = state_q;
        limit_d    = limit_q;
        beatCnt_d  = beatCnt_q;
        tlpCnt_d   = tlpCnt_q;
        winRst_d   = 1'b0;
        limEff     = (state_q == ARMED) ? beat_limit : limit_q;
        limMin     = (limEff == 12'd0) ? 12'd1 : limEff;
        cntNext    = {1'b0, beatCnt_q} + 13'd1;

        if (abort) begin
            state_d = IDLE;
        end else if (arm) begin
            state_d   = ARMED;
            winRst_d  = 1'b1;
            beatCnt_d = 12'd0;
            tlpCnt_d  = 16'd0;
        end else begin
            case (state_q)
                ARMED: begin
                    if (match) begin
                        fwd     = 1'b1;
                        state_d = CAPTURE;
                        limit_d = beat_limit;
                    end
                end
                CAPTURE: begin
                    if (beat) begin
                        fwd = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        if (fwd) begin
            beatCnt_d = cntNext[11:0];
            if (st_sop0 && (tlpCnt_q != 16'hFFFF)) begin
                tlpCnt_d = tlpCnt_q + 16'd1;
            end
            if ((st_eop0 && (cntNext >= {1'b0, limMin})) || (cntNext == MAX_CNT)) begin
                state_d = DONE;
            end
        end

        capValid_d = fwd;
        capSop_d   = fwd ? st_sop0  : capSop_q;
        capEop_d   = fwd ? st_eop0  : capEop_q;
        capBe_d    = fwd ? st_be0   : capBe_q;
        capData_d  = fwd ? st_data0 : capData_q;
    end

    // State, counters and the registered capture stream.
    always_ff @(posedge trn_clk or posedge trn_rst) begin
        if (trn_rst) begin
            state_q    <= IDLE;
            limit_q    <= 12'd0;
            beatCnt_q  <= 12'd0;
            tlpCnt_q   <= 16'd0;
            winRst_q   <= 1'b0;
            capValid_q <= 1'b0;
            capSop_q   <= 1'b0;
            capEop_q   <= 1'b0;
            capBe_q    <= 8'd0;
            capData_q  <= 64'd0;
        end else begin
            state_q    <= state_d;
            limit_q    <= limit_d;
            beatCnt_q  <= beatCnt_d;
            tlpCnt_q   <= tlpCnt_d;
            winRst_q   <= winRst_d;
            capValid_q <= capValid_d;
            capSop_q   <= capSop_d;
            capEop_q   <= capEop_d;
            capBe_q    <= capBe_d;
            capData_q  <= capData_d;
        end
    end

    assign cap_valid = capValid_q;
    assign cap_ready = capValid_q;
    assign cap_sop   = capSop_q;
    assign cap_eop   = capEop_q;
    assign cap_be    = capBe_q;
    assign cap_data  = capData_q;
    assign win_rst   = winRst_q;
    assign state     = state_q;
    assign done      = (state_q == DONE);
    assign beat_cnt  = beatCnt_q;
    assign tlp_cnt   = tlpCnt_q;

endmodule

// File: tb/tb_tlp_win_trigger.sv
// Directed bench for tlp_win_trigger.
// Beats expected in the capture window are queued as they are driven.
// A negedge monitor pops the queue and compares against cap_*.
module tb_tlp_win_trigger;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic        trn_clk = 1'b0;
    logic        trn_rst;
    logic        st_valid0, st_ready0, st_sop0, st_eop0;
    logic [7:0]  st_be0;
    logic [63:0] st_data0;
    logic        arm, abort;
    logic [7:0]  trig_mask, trig_value;
    logic [11:0] beat_limit;
    logic        cap_valid, cap_ready, cap_sop, cap_eop;
    logic [7:0]  cap_be;
    logic [63:0] cap_data;
    logic        win_rst;
    logic [1:0]  state;
    logic        done;
    logic [11:0] beat_cnt;
    logic [15:0] tlp_cnt;

    int checkCnt = 0;
    int passCnt  = 0;
    int failCnt  = 0;
    logic [73:0] sb[$];
    logic [73:0] expBeat;

    tlp_win_trigger #(.MAX_BEATS(4095)) dut (
        .trn_clk(trn_clk), .trn_rst(trn_rst),
        .st_valid0(st_valid0), .st_ready0(st_ready0), .st_sop0(st_sop0), .st_eop0(st_eop0),
        .st_be0(st_be0), .st_data0(st_data0),
        .arm(arm), .abort(abort),
        .trig_mask(trig_mask), .trig_value(trig_value), .beat_limit(beat_limit),
        .cap_valid(cap_valid), .cap_ready(cap_ready), .cap_sop(cap_sop), .cap_eop(cap_eop),
        .cap_be(cap_be), .cap_data(cap_data),
        .win_rst(win_rst), .state(state), .done(done),
        .beat_cnt(beat_cnt), .tlp_cnt(tlp_cnt)
    );

    always #5 trn_clk = ~trn_clk;

    task automatic checkOutput(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checkCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of stimulus. If the beat should reach the window, its
    // expected image is queued at the sampling edge.
    task automatic applyStimulus(input logic v, input logic sop, input logic eop,
                                 input logic [7:0] fmt, input logic [55:0] low,
                                 input logic a, input logic ab, input logic fwd);
        logic [63:0] d;
        logic [7:0]  be;
        d = {fmt, low};
        be = low[7:0] ^ 8'h5A;
        st_valid0 = v;
        st_ready0 = 1'b1;
        st_sop0   = sop;
        st_eop0   = eop;
        st_data0  = d;
        st_be0    = be;
        arm       = a;
        abort     = ab;
        @(posedge trn_clk);
        if (fwd) sb.push_back({sop, eop, be, d});
        #1;
        st_valid0 = 1'b0;
        st_sop0   = 1'b0;
        st_eop0   = 1'b0;
        arm       = 1'b0;
        abort     = 1'b0;
    endtask

    // Capture-stream monitor: every cap_valid must match the oldest queued beat.
    always @(negedge trn_clk) begin
        if (!trn_rst) begin
            if (cap_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checkOutput("spuriousCapValid", cap_valid, 1'b0);
                end else begin
                    expBeat = sb.pop_front();
                    checkOutput("capBeat", {cap_sop, cap_eop, cap_be, cap_data}, expBeat);
                    checkOutput("capReady", cap_ready, 1'b1);
                end
            end else if (sb.size() != 0) begin
                checkOutput("missingCapValid", cap_valid, 1'b1);
                sb.delete();
            end
        end
    end

    initial begin
        trn_rst = 1'b0;
        st_valid0 = 1'b0; st_ready0 = 1'b1; st_sop0 = 1'b0; st_eop0 = 1'b0;
        st_be0 = 8'd0; st_data0 = 64'd0; arm = 1'b0; abort = 1'b0;
        trig_mask = 8'hFF; trig_value = 8'h40; beat_limit = 12'd2;
        #1 trn_rst = 1'b1;
        #1;
        checkOutput("rstState", state, S_IDLE);
        checkOutput("rstDone", done, 1'b0);
        checkOutput("rstCapValid", cap_valid, 1'b0);
        checkOutput("rstWinRst", win_rst, 1'b0);
        checkOutput("rstBeatCnt", beat_cnt, 12'd0);
        checkOutput("rstTlpCnt", tlp_cnt, 16'd0);
        checkOutput("rstCapData", cap_data, 64'd0);
        #6 trn_rst = 1'b0;

        // 3-beat MWr with limit 2
        applyStimulus(0, 0, 0, 8'h00, 56'h0, 1, 0, 0);
        checkOutput("t1ArmState", state, S_ARMED);
        checkOutput("t1WinRst", win_rst, 1'b1);
        applyStimulus(1, 1, 0, 8'h40, 56'h11, 0, 0, 1);
        checkOutput("t1CapState", state, S_CAPTURE);
        checkOutput("t1WinRstLow", win_rst, 1'b0);
        checkOutput("t1Beat1", beat_cnt, 12'd1);
        checkOutput("t1Tlp1", tlp_cnt, 16'd1);
        applyStimulus(1, 0, 0, 8'h12, 56'h22, 0, 0, 1);
        checkOutput("t1Beat2", beat_cnt, 12'd2);
        checkOutput("t1MidState", state, S_CAPTURE);
        applyStimulus(1, 0, 1, 8'h33, 56'h33, 0, 0, 1);
        checkOutput("t1DoneState", state, S_DONE);
        checkOutput("t1Done", done, 1'b1);
        checkOutput("t1Beat3", beat_cnt, 12'd3);
        checkOutput("t1TlpFinal", tlp_cnt, 16'd1);
        applyStimulus(1, 1, 1, 8'h40, 56'h44, 0, 0, 0);
        checkOutput("t1IgnoreInDone", beat_cnt, 12'd3);

        // non-matching MRd skipped, capture starts at 0x40; limit held from match
        applyStimulus(0, 0, 0, 8'h00, 56'h0, 1, 0, 0);
        checkOutput("t2ArmClrBeat", beat_cnt, 12'd0);
        checkOutput("t2ArmClrTlp", tlp_cnt, 16'd0);
        checkOutput("t2ArmDoneLow", done, 1'b0);
        applyStimulus(1, 1, 1, 8'h00, 56'h55, 0, 0, 0);
        checkOutput("t2MrdState", state, S_ARMED);
        checkOutput("t2MrdBeat", beat_cnt, 12'd0);
        applyStimulus(1, 1, 0, 8'h40, 56'h66, 0, 0, 1);
        checkOutput("t2MatchState", state, S_CAPTURE);
        beat_limit = 12'd4;
        applyStimulus(1, 0, 1, 8'h00, 56'h77, 0, 0, 1);
        checkOutput("t2DoneState", state, S_DONE);
        checkOutput("t2Beat", beat_cnt, 12'd2);

        // single-beat TLP, limit 1 -> ARMED straight to DONE
        beat_limit = 12'd1;
        applyStimulus(0, 0, 0, 8'h00, 56'h0, 1, 0, 0);
        applyStimulus(1, 1, 1, 8'h40, 56'h88, 0, 0, 1);
        checkOutput("t3State", state, S_DONE);
        checkOutput("t3Beat", beat_cnt, 12'd1);
        checkOutput("t3Tlp", tlp_cnt, 16'd1);

        // partial mask, limit 0 behaves as 1
        trig_mask = 8'hF0; beat_limit = 12'd0;
        applyStimulus(0, 0, 0, 8'h00, 56'h0, 1, 0, 0);
        applyStimulus(1, 1, 1, 8'h55, 56'h99, 0, 0, 0);
        checkOutput("t3bNoMatch", state, S_ARMED);
        applyStimulus(1, 1, 1, 8'h45, 56'hAA, 0, 0, 1);
        checkOutput("t3bState", state, S_DONE);
        checkOutput("t3bBeat", beat_cnt, 12'd1);

        // window full after 4095 beats mid-TLP
        trig_mask = 8'hFF; beat_limit = 12'hFFF;
        applyStimulus(0, 0, 0, 8'h00, 56'h0, 1, 0, 0);
        for (int i = 0; i < 4095; i++) begin
            applyStimulus(1, (i == 0), 0, (i == 0) ? 8'h40 : 8'(i), 56'(i * 3), 0, 0, 1);
            if (i == 4093) begin
                checkOutput("t4PreState", state, S_CAPTURE);
                checkOutput("t4PreBeat", beat_cnt, 12'hFFE);
            end
        end
        checkOutput("t4State", state, S_DONE);
        checkOutput("t4Beat", beat_cnt, 12'hFFF);
        checkOutput("t4Tlp", tlp_cnt, 16'd1);
        applyStimulus(1, 0, 0, 8'h01, 56'h1, 0, 0, 0);
        applyStimulus(1, 0, 1, 8'h02, 56'h2, 0, 0, 0);
        checkOutput("t4BeatHeld", beat_cnt, 12'hFFF);

        // re-arm mid-capture drops the coinciding beat; arm+abort goes IDLE
        beat_limit = 12'd4;
        applyStimulus(0, 0, 0, 8'h00, 56'h0, 1, 0, 0);
        applyStimulus(1, 1, 0, 8'h40, 56'hBB, 0, 0, 1);
        applyStimulus(1, 0, 0, 8'h01, 56'hCC, 1, 0, 0);
        checkOutput("t5RearmState", state, S_ARMED);
        checkOutput("t5RearmBeat", beat_cnt, 12'd0);
        checkOutput("t5RearmTlp", tlp_cnt, 16'd0);
        checkOutput("t5RearmWinRst", win_rst, 1'b1);
        applyStimulus(1, 1, 0, 8'h40, 56'hDD, 0, 0, 1);
        checkOutput("t5CapState", state, S_CAPTURE);
        checkOutput("t5CapBeat", beat_cnt, 12'd1);
        applyStimulus(1, 0, 0, 8'h02, 56'hEE, 1, 1, 0);
        checkOutput("t5AbortState", state, S_IDLE);
        checkOutput("t5AbortWinRst", win_rst, 1'b0);
        checkOutput("t5AbortCapValid", cap_valid, 1'b0);
        checkOutput("t5AbortDone", done, 1'b0);

        // asynchronous reset mid-capture
        applyStimulus(0, 0, 0, 8'h00, 56'h0, 1, 0, 0);
        applyStimulus(1, 1, 0, 8'h40, 56'h123, 0, 0, 1);
        applyStimulus(1, 0, 0, 8'h07, 56'h456, 0, 0, 1);
        checkOutput("t6PreCapValid", cap_valid, 1'b1);
        #2 trn_rst = 1'b1;
        #1;
        checkOutput("t6RstCapValid", cap_valid, 1'b0);
        checkOutput("t6RstCapSop", cap_sop, 1'b0);
        checkOutput("t6RstCapData", cap_data, 64'd0);
        checkOutput("t6RstCapBe", cap_be, 8'd0);
        checkOutput("t6RstState", state, S_IDLE);
        checkOutput("t6RstBeat", beat_cnt, 12'd0);
        checkOutput("t6RstTlp", tlp_cnt, 16'd0);
        sb.delete();
        @(posedge trn_clk);
        #3;
        checkOutput("t6HeldState", state, S_IDLE);
        trn_rst = 1'b0;
        applyStimulus(1, 1, 0, 8'h40, 56'h789, 0, 0, 0);
        checkOutput("t6PostState", state, S_IDLE);
        checkOutput("t6PostBeat", beat_cnt, 12'd0);
        applyStimulus(0, 0, 0, 8'h00, 56'h0, 0, 0, 0);
        checkOutput("t6PostCapValid", cap_valid, 1'b0);

        checkOutput("scoreboardDrained", 80'(sb.size()), 80'd0);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
